// File: rtl/dvi_encoder.sv
// DVI/TMDS 8b/10b encoder for three colour channels.
// Two-stage pipeline: transition minimisation, then DC balancing.

module tmds_channel (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] d,
    input  logic       de,
    input  logic [1:0] c,
    output logic [9:0] tmds
);

    localparam logic [9:0] CTRL_00 = 10'b1101010100;
    localparam logic [9:0] CTRL_01 = 10'b0010101011;
    localparam logic [9:0] CTRL_10 = 10'b0101010100;
    localparam logic [9:0] CTRL_11 = 10'b1010101011;

    function automatic logic [3:0] ones8(input logic [7:0] v);
        logic [3:0] s;
        s = '0;
        for (int i = 0; i < 8; i++) s = s + {3'b000, v[i]};
        return s;
    endfunction

    logic [3:0] n1d;
    logic       use_xnor;
    logic [8:0] qm;

    logic [8:0] qm_q;
    logic       de_q;
    logic [1:0] c_q;

    logic [3:0] n1;
    logic [3:0] n0;
    logic [4:0] diff;
    logic [4:0] cnt;
    logic [4:0] cnt_n;
    logic [9:0] sym;
    logic       cnt_pos;
    logic       cnt_neg;

    always_comb begin
        n1d      = ones8(d);
        use_xnor = (n1d > 4'd4) || ((n1d == 4'd4) && !d[0]);
        qm       = '0;
        qm[0]    = d[0];
        for (int i = 1; i < 8; i++)
            qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
        qm[8]    = ~use_xnor;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            qm_q <= '0;
            de_q <= 1'b0;
            c_q  <= 2'b00;
        end else begin
            qm_q <= qm;
            de_q <= de;
            c_q  <= c;
        end
    end

    // cnt is 5-bit two's complement; bit 4 is the sign
    always_comb begin
        n1      = ones8(qm_q[7:0]);
        n0      = 4'd8 - n1;
        diff    = {1'b0, n1} - {1'b0, n0};
        cnt_pos = !cnt[4] && (cnt != 5'd0);
        cnt_neg = cnt[4];
        sym     = CTRL_00;
        cnt_n   = '0;
        if (!de_q) begin
            unique case (c_q)
                2'b00: sym = CTRL_00;
                2'b01: sym = CTRL_01;
                2'b10: sym = CTRL_10;
                2'b11: sym = CTRL_11;
            endcase
            cnt_n = '0;
        end else if ((cnt == 5'd0) || (n1 == n0)) begin
            sym   = {~qm_q[8], qm_q[8],
                     qm_q[8] ? qm_q[7:0] : ~qm_q[7:0]};
            cnt_n = qm_q[8] ? cnt + diff : cnt - diff;
        end else if ((cnt_pos && (n1 > n0)) || (cnt_neg && (n0 > n1))) begin
            sym   = {1'b1, qm_q[8], ~qm_q[7:0]};
            cnt_n = cnt + {3'b000, qm_q[8], 1'b0} - diff;
        end else begin
            sym   = {1'b0, qm_q[8], qm_q[7:0]};
            cnt_n = cnt - {3'b000, ~qm_q[8], 1'b0} + diff;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt  <= '0;
            tmds <= CTRL_00;
        end else begin
            cnt  <= cnt_n;
            tmds <= sym;
        end
    end

endmodule

module dvi_encoder (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] r,
    input  logic [7:0] g,
    input  logic [7:0] b,
    input  logic       de,
    input  logic       hsync,
    input  logic       vsync,
    output logic [9:0] tmds_r,
    output logic [9:0] tmds_g,
    output logic [9:0] tmds_b
);

    tmds_channel u_red (
        .clock (clock),
        .reset (reset),
        .d     (r),
        .de    (de),
        .c     (2'b00),
        .tmds  (tmds_r)
    );

    tmds_channel u_green (
        .clock (clock),
        .reset (reset),
        .d     (g),
        .de    (de),
        .c     (2'b00),
        .tmds  (tmds_g)
    );

    // only blue carries the sync pair during blanking
    tmds_channel u_blue (
        .clock (clock),
        .reset (reset),
        .d     (b),
        .de    (de),
        .c     ({vsync, hsync}),
        .tmds  (tmds_b)
    );

endmodule

// File: tb/tb_dvi_encoder.sv
// Scoreboard bench for dvi_encoder: reference TMDS model,
// sync/blanking codes, DC balance tracking and async reset.

module tb_dvi_encoder;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] r = '0;
    logic [7:0] g = '0;
    logic [7:0] b = '0;
    logic       de = 1'b0;
    logic       hsync = 1'b0;
    logic       vsync = 1'b0;
    logic [9:0] tmds_r;
    logic [9:0] tmds_g;
    logic [9:0] tmds_b;

    localparam logic [9:0] RST_SYM = 10'b1101010100;

    dvi_encoder dut (
        .clock  (clock),
        .reset  (reset),
        .r      (r),
        .g      (g),
        .b      (b),
        .de     (de),
        .hsync  (hsync),
        .vsync  (vsync),
        .tmds_r (tmds_r),
        .tmds_g (tmds_g),
        .tmds_b (tmds_b)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [9:0] sr;
        logic [9:0] sg;
        logic [9:0] sb;
        logic       de;
        int         cr;
        int         cg;
        int         cb;
    } exp_t;

    exp_t q[$];
    int   mc[3];
    int   acc[3];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string tag, input integer act, input integer exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic model_ch(input logic [7:0] d, input logic den,
                            input logic [1:0] c, inout int cnt,
                            output logic [9:0] sym);
        logic [8:0] qv;
        int         n1;
        int         n0;
        bit         xn;
        if (!den) begin
            case (c)
                2'b00: sym = 10'b1101010100;
                2'b01: sym = 10'b0010101011;
                2'b10: sym = 10'b0101010100;
                default: sym = 10'b1010101011;
            endcase
            cnt = 0;
        end else begin
            xn = ($countones(d) > 4) || ($countones(d) == 4 && d[0] == 1'b0);
            qv[0] = d[0];
            for (int i = 1; i < 8; i++)
                qv[i] = xn ? ~(qv[i-1] ^ d[i]) : (qv[i-1] ^ d[i]);
            qv[8] = !xn;
            n1 = $countones(qv[7:0]);
            n0 = 8 - n1;
            if (cnt == 0 || n1 == n0) begin
                sym = {~qv[8], qv[8], qv[8] ? qv[7:0] : ~qv[7:0]};
                cnt = cnt + (qv[8] ? n1 - n0 : n0 - n1);
            end else if ((cnt > 0 && n1 > n0) || (cnt < 0 && n0 > n1)) begin
                sym = {1'b1, qv[8], ~qv[7:0]};
                cnt = cnt + 2 * int'(qv[8]) + n0 - n1;
            end else begin
                sym = {1'b0, qv[8], qv[7:0]};
                cnt = cnt - 2 * (qv[8] ? 0 : 1) + n1 - n0;
            end
        end
    endtask

    function automatic int disp(input logic [9:0] s);
        return 2 * $countones(s) - 10;
    endfunction

    task automatic track(input int ch, input string tag,
                         input logic [9:0] s, input logic den, input int mcnt);
        if (den) begin
            acc[ch] += disp(s);
            check({tag, "_disp"}, acc[ch], mcnt);
            check({tag, "_bound"}, (acc[ch] >= -10 && acc[ch] <= 10), 1);
        end else begin
            acc[ch] = 0;
        end
    endtask

    task automatic step(input logic [7:0] vr, input logic [7:0] vg,
                        input logic [7:0] vb, input logic vde,
                        input logic vh, input logic vv);
        exp_t e;
        r = vr; g = vg; b = vb; de = vde; hsync = vh; vsync = vv;
        model_ch(vr, vde, 2'b00, mc[0], e.sr);
        model_ch(vg, vde, 2'b00, mc[1], e.sg);
        model_ch(vb, vde, {vv, vh}, mc[2], e.sb);
        e.de = vde;
        e.cr = mc[0];
        e.cg = mc[1];
        e.cb = mc[2];
        q.push_back(e);
        @(posedge clock);
        #1;
        if (q.size() > 1) begin
            e = q.pop_front();
            check("tmds_r", tmds_r, e.sr);
            check("tmds_g", tmds_g, e.sg);
            check("tmds_b", tmds_b, e.sb);
            track(0, "red", tmds_r, e.de, e.cr);
            track(1, "green", tmds_g, e.de, e.cg);
            track(2, "blue", tmds_b, e.de, e.cb);
        end else begin
            check("post_rst_r", tmds_r, RST_SYM);
            check("post_rst_g", tmds_g, RST_SYM);
            check("post_rst_b", tmds_b, RST_SYM);
        end
    endtask

    task automatic do_reset();
        #1 reset = 1'b1;
        #1;
        check("rst_r", tmds_r, RST_SYM);
        check("rst_g", tmds_g, RST_SYM);
        check("rst_b", tmds_b, RST_SYM);
        q.delete();
        for (int i = 0; i < 3; i++) begin
            mc[i] = 0;
            acc[i] = 0;
        end
        @(posedge clock);
        #2 reset = 1'b0;
    endtask

    task automatic rand_pixels(input int n);
        for (int i = 0; i < n; i++)
            step(8'($urandom), 8'($urandom), 8'($urandom), 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            mc[i] = 0;
            acc[i] = 0;
        end
        // asynchronous reset before any clock edge
        #2 reset = 1'b1;
        #1;
        check("init_rst_r", tmds_r, RST_SYM);
        check("init_rst_g", tmds_g, RST_SYM);
        check("init_rst_b", tmds_b, RST_SYM);
        @(posedge clock);
        @(posedge clock);
        #2 reset = 1'b0;

        step(8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
        step(8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
        check("blank_h_b", tmds_b, 10'b0010101011);
        check("blank_h_r", tmds_r, 10'b1101010100);
        check("blank_h_g", tmds_g, 10'b1101010100);
        step(8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
        step(8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
        check("blank_hv_b", tmds_b, 10'b1010101011);

        step(8'hFF, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
        step(8'hFF, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
        check("zero_run0_b", tmds_b, 10'b0100000000);
        check("full_r", tmds_r, 10'b1000000000);
        check("full_r_cnt", acc[0], -8);
        step(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        check("zero_run1_b", tmds_b, 10'b1111111111);
        check("zero_run1_cnt", acc[2], 2);
        step(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);

        for (int line = 0; line < 10; line++) begin
            rand_pixels(640);
            for (int i = 0; i < 40; i++)
                step(8'($urandom), 8'($urandom), 8'($urandom), 1'b0,
                     1'($urandom), 1'($urandom));
        end

        rand_pixels(100);
        do_reset();
        step(8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
        step(8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
        check("after_rst_b", tmds_b, 10'b0100000000);
        rand_pixels(50);
        for (int i = 0; i < 4; i++)
            step(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
